// File: rtl/sample_feeder.sv
// -----------------------------------------------------------------------------
// sample_feeder
//
// Feeds a FIR-style consumer with one frame of TAPS delayed samples for every
// accepted input sample. Incoming samples go into a TAPS-entry circular delay
// line. For each one the block issues taps k = 0..TAPS-1 on consecutive
// cycles, where tap k carries x[n-k] (the newest sample first).
//
// A single pending register absorbs one extra sample while a frame is in
// flight. Frames therefore run back-to-back without a bubble when the source
// keeps in_valid high.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous reset, active low
//   in_valid    : sample offered on in_data
//   in_data     : signed sample, DW bits
//   in_ready    : sample can be accepted this cycle
//   tap_valid   : tap_data / tap_idx valid this cycle
//   tap_data    : delayed sample x[n-k]
//   tap_idx     : tap index k
//   frame_start : high with k = 0
//   frame_end   : high with k = TAPS-1
//   primed      : sticky, TAPS samples accepted since reset
// -----------------------------------------------------------------------------
module sample_feeder #(
   parameter int TAPS = 24,
   parameter int DW   = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_data,
   output logic                 in_ready,
   output logic                 tap_valid,
   output logic signed [DW-1:0] tap_data,
   output logic [4:0]           tap_idx,
   output logic                 frame_start,
   output logic                 frame_end,
   output logic                 primed
);

   localparam logic [4:0] LAST  = 5'(TAPS - 1);
   localparam logic [5:0] TAPS6 = 6'(TAPS);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t               state_q, state_d;
   logic [4:0]           k_q, k_d;
   logic [4:0]           wptr_q, wptr_d;
   logic signed [DW-1:0] dline_q [TAPS];
   logic signed [DW-1:0] dline_d [TAPS];
   logic signed [DW-1:0] pend_q, pend_d;
   logic                 pend_full_q, pend_full_d;
   logic [5:0]           cnt_q, cnt_d;

   logic                 tap_valid_q, tap_valid_d;
   logic signed [DW-1:0] tap_data_q, tap_data_d;
   logic [4:0]           tap_idx_q, tap_idx_d;
   logic                 frame_start_q, frame_start_d;
   logic                 frame_end_q, frame_end_d;

   logic                 accept;
   logic [4:0]           wptr_inc;
   logic [5:0]           rd_sum;
   logic [5:0]           rd_idx;

   // in_ready is gated by rst so it reads 0 for as long as reset is held.
   assign in_ready    = rst && ((state_q == IDLE) || !pend_full_q);
   assign accept      = in_valid && in_ready;

   assign tap_valid   = tap_valid_q;
   assign tap_data    = tap_data_q;
   assign tap_idx     = tap_idx_q;
   assign frame_start = frame_start_q;
   assign frame_end   = frame_end_q;
   assign primed      = (cnt_q == TAPS6);

   always_comb begin
      // The newest sample sits just behind wptr. wptr only moves on the final
      // tap edge, so it is stable for the whole frame. This also means tap
      // TAPS-1 reads the slot at wptr, which is the slot about to be
      // overwritten. Because the read is registered on the same edge as the
      // write, it sees the old contents.
      rd_sum   = {1'b0, wptr_q} + TAPS6 - 6'd1 - {1'b0, k_q};
      rd_idx   = (rd_sum >= TAPS6) ? (rd_sum - TAPS6) : rd_sum;
      wptr_inc = (wptr_q == LAST) ? 5'd0 : (wptr_q + 5'd1);

      state_d       = state_q;
      k_d           = k_q;
      wptr_d        = wptr_q;
      dline_d       = dline_q;
      pend_d        = pend_q;
      pend_full_d   = pend_full_q;
      cnt_d         = cnt_q;
      tap_valid_d   = 1'b0;
      tap_data_d    = '0;
      tap_idx_d     = 5'd0;
      frame_start_d = 1'b0;
      frame_end_d   = 1'b0;

      if (accept && (cnt_q != TAPS6)) begin
         cnt_d = cnt_q + 6'd1;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               dline_d[wptr_q] = in_data;
               wptr_d          = wptr_inc;
               k_d             = 5'd0;
               state_d         = STREAM;
            end
         end

         STREAM: begin
            tap_valid_d   = 1'b1;
            tap_data_d    = dline_q[rd_idx];
            tap_idx_d     = k_q;
            frame_start_d = (k_q == 5'd0);
            frame_end_d   = (k_q == LAST);

            if (k_q == LAST) begin
               k_d = 5'd0;
               if (pend_full_q) begin
                  dline_d[wptr_q] = pend_q;
                  pend_full_d     = 1'b0;
                  wptr_d          = wptr_inc;
               end else if (accept) begin
                  dline_d[wptr_q] = in_data;
                  wptr_d          = wptr_inc;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               k_d = k_q + 5'd1;
               // accept implies the pending slot is empty here.
               if (accept) begin
                  pend_d      = in_data;
                  pend_full_d = 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         k_q           <= 5'd0;
         wptr_q        <= 5'd0;
         for (int i = 0; i < TAPS; i++) dline_q[i] <= '0;
         pend_q        <= '0;
         pend_full_q   <= 1'b0;
         cnt_q         <= 6'd0;
         tap_valid_q   <= 1'b0;
         tap_data_q    <= '0;
         tap_idx_q     <= 5'd0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         wptr_q        <= wptr_d;
         dline_q       <= dline_d;
         pend_q        <= pend_d;
         pend_full_q   <= pend_full_d;
         cnt_q         <= cnt_d;
         tap_valid_q   <= tap_valid_d;
         tap_data_q    <= tap_data_d;
         tap_idx_q     <= tap_idx_d;
         frame_start_q <= frame_start_d;
         frame_end_q   <= frame_end_d;
      end
   end

endmodule

// File: tb/tb_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_sample_feeder
//
// Directed bench for sample_feeder with the default TAPS=24, DW=10 settings.
// Each scenario task drives its own stimulus and compares the captured taps
// against values worked out by hand from the stimulus.
// -----------------------------------------------------------------------------
module tb_sample_feeder;

   localparam int TAPS = 24;
   localparam int DW   = 10;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] in_data = '0;
   logic                 in_ready;
   logic                 tap_valid;
   logic signed [DW-1:0] tap_data;
   logic [4:0]           tap_idx;
   logic                 frame_start;
   logic                 frame_end;
   logic                 primed;

   int n_checks = 0;
   int n_fail   = 0;

   // One captured frame window: slot 0 is the cycle after acceptance,
   // slots 1..24 hold taps 0..23, and slot 25 is the cycle after the frame.
   logic                 c_valid [30];
   logic signed [DW-1:0] c_data  [30];
   logic [4:0]           c_idx   [30];
   logic                 c_fs    [30];
   logic                 c_fe    [30];
   logic                 c_rdy   [30];

   sample_feeder #(.TAPS(TAPS), .DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .tap_valid   (tap_valid),
      .tap_data    (tap_data),
      .tap_idx     (tap_idx),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .primed      (primed)
   );

   always #5 clk = ~clk;

   task automatic apply_reset();
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Offers v and returns 1 ns after the posedge that accepted it.
   task automatic send_one(input logic signed [DW-1:0] v);
      int w;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v;
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic capture(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         c_valid[c] = tap_valid;
         c_data[c]  = tap_data;
         c_idx[c]   = tap_idx;
         c_fs[c]    = frame_start;
         c_fe[c]    = frame_end;
         c_rdy[c]   = in_ready;
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      in_valid = 1'b1;
      in_data  = 10'sd3;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({in_ready, tap_valid, tap_data, tap_idx, frame_start, frame_end, primed} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: rdy=%b vld=%b data=%0d idx=%0d fs=%b fe=%b primed=%b required all 0",
                  in_ready, tap_valid, tap_data, tap_idx, frame_start, frame_end, primed);
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_single();
      apply_reset();
      send_one(10'sd5);
      capture(26);
      n_checks++;
      if (c_valid[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pre_valid: tap_valid=%b required 0", c_valid[0]);
      end
      for (int k = 0; k < TAPS; k++) begin
         logic signed [DW-1:0] exp_d;
         exp_d = (k == 0) ? 10'sd5 : 10'sd0;
         n_checks++;
         if (c_valid[k+1] !== 1'b1 || c_data[k+1] !== exp_d || c_idx[k+1] !== 5'(k) ||
             c_fs[k+1] !== (k == 0) || c_fe[k+1] !== (k == TAPS-1)) begin
            n_fail++;
            $display("FAIL single_tap%0d: vld=%b data=%0d idx=%0d fs=%b fe=%b required vld=1 data=%0d idx=%0d fs=%b fe=%b",
                     k, c_valid[k+1], c_data[k+1], c_idx[k+1], c_fs[k+1], c_fe[k+1],
                     exp_d, k, (k == 0), (k == TAPS-1));
         end
      end
      n_checks++;
      if (c_valid[25] !== 1'b0 || c_rdy[25] !== 1'b1) begin
         n_fail++;
         $display("FAIL single_idle_after: vld=%b rdy=%b required vld=0 rdy=1", c_valid[25], c_rdy[25]);
      end
   endtask

   task automatic test_ordering();
      apply_reset();
      for (int i = 1; i <= TAPS; i++) begin
         if (i == TAPS) begin
            n_checks++;
            if (primed !== 1'b0) begin
               n_fail++;
               $display("FAIL primed_early: primed=%b required 0 before acceptance 24", primed);
            end
         end
         send_one(10'(i));
         if (i < TAPS) repeat (27) @(negedge clk);
      end
      n_checks++;
      if (primed !== 1'b1) begin
         n_fail++;
         $display("FAIL primed_rise: primed=%b required 1 after acceptance 24", primed);
      end
      capture(26);
      for (int k = 0; k < TAPS; k++) begin
         n_checks++;
         if (c_valid[k+1] !== 1'b1 || c_data[k+1] !== 10'(TAPS - k)) begin
            n_fail++;
            $display("FAIL order_tap%0d: vld=%b data=%0d required vld=1 data=%0d",
                     k, c_valid[k+1], c_data[k+1], TAPS - k);
         end
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 1; i <= 30; i++) begin
         send_one(10'(i));
         if (i < 30) repeat (27) @(negedge clk);
      end
      capture(26);
      for (int k = 0; k < TAPS; k++) begin
         n_checks++;
         if (c_valid[k+1] !== 1'b1 || c_data[k+1] !== 10'(30 - k)) begin
            n_fail++;
            $display("FAIL wrap_tap%0d: vld=%b data=%0d required vld=1 data=%0d",
                     k, c_valid[k+1], c_data[k+1], 30 - k);
         end
      end
   endtask

   task automatic test_extremes();
      logic signed [DW-1:0] vneg;
      logic signed [DW-1:0] vpos;
      vneg = 10'h200;
      vpos = 10'h1FF;
      apply_reset();
      send_one(vneg);
      repeat (27) @(negedge clk);
      send_one(vpos);
      capture(26);
      n_checks++;
      if (c_data[1] !== vpos || !(c_data[1] > 0)) begin
         n_fail++;
         $display("FAIL extreme_pos: data=%0d required 511", c_data[1]);
      end
      n_checks++;
      if (c_data[2] !== vneg || !(c_data[2] < 0)) begin
         n_fail++;
         $display("FAIL extreme_neg: data=%0d required -512", c_data[2]);
      end
      n_checks++;
      if (c_data[3] !== 10'sd0) begin
         n_fail++;
         $display("FAIL extreme_tap2: data=%0d required 0", c_data[3]);
      end
   endtask

   task automatic test_back_to_back();
      logic                 b_valid [80];
      logic signed [DW-1:0] b_data  [80];
      logic                 b_fs    [80];
      logic                 b_rdy   [80];
      logic                 acc;
      int                   v;
      logic                 gap;
      logic                 rdy_bad;
      apply_reset();
      @(negedge clk);
      v        = 1;
      in_valid = 1'b1;
      in_data  = 10'(v);
      for (int c = 0; c < 80; c++) begin
         acc = in_ready;
         @(posedge clk);
         @(negedge clk);
         b_valid[c] = tap_valid;
         b_data[c]  = tap_data;
         b_fs[c]    = frame_start;
         b_rdy[c]   = in_ready;
         if (acc) begin
            v++;
            in_data = 10'(v);
         end
      end
      in_valid = 1'b0;

      gap = 1'b0;
      for (int c = 1; c <= 3 * TAPS; c++) if (b_valid[c] !== 1'b1) gap = 1'b1;
      n_checks++;
      if (gap) begin
         n_fail++;
         $display("FAIL b2b_continuous: tap_valid dropped within 3 frames, required continuous");
      end
      for (int f = 0; f < 3; f++) begin
         n_checks++;
         if (b_fs[1 + f*TAPS] !== 1'b1 || b_data[1 + f*TAPS] !== 10'(f + 1)) begin
            n_fail++;
            $display("FAIL b2b_frame%0d_tap0: fs=%b data=%0d required fs=1 data=%0d",
                     f, b_fs[1 + f*TAPS], b_data[1 + f*TAPS], f + 1);
         end
      end
      n_checks++;
      if (b_data[2 + TAPS] !== 10'sd1) begin
         n_fail++;
         $display("FAIL b2b_frame1_tap1: data=%0d required 1", b_data[2 + TAPS]);
      end
      rdy_bad = 1'b0;
      for (int c = 1; c < TAPS; c++) if (b_rdy[c] !== 1'b0) rdy_bad = 1'b1;
      n_checks++;
      if (rdy_bad || b_rdy[TAPS] !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_ready: ready_high_while_full=%b ready_at_last=%b required 0 and 1",
                  rdy_bad, b_rdy[TAPS]);
      end
   endtask

   task automatic test_reset_mid_frame();
      int w;
      apply_reset();
      send_one(10'sd7);
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(tap_valid === 1'b1 && tap_idx === 5'd10) && w < 40);
      n_checks++;
      if (tap_idx !== 5'd10) begin
         n_fail++;
         $display("FAIL midrst_reach_tap10: tap_idx=%0d required 10", tap_idx);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, tap_valid, tap_data, tap_idx, frame_start, frame_end, primed} !== '0) begin
         n_fail++;
         $display("FAIL midrst_outputs: rdy=%b vld=%b data=%0d idx=%0d fs=%b fe=%b required all 0",
                  in_ready, tap_valid, tap_data, tap_idx, frame_start, frame_end);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || tap_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_release: rdy=%b vld=%b required rdy=1 vld=0", in_ready, tap_valid);
      end
      send_one(10'sd9);
      capture(26);
      n_checks++;
      if (c_valid[1] !== 1'b1 || c_data[1] !== 10'sd9) begin
         n_fail++;
         $display("FAIL midrst_new_tap0: vld=%b data=%0d required vld=1 data=9", c_valid[1], c_data[1]);
      end
      for (int k = 1; k < TAPS; k++) begin
         n_checks++;
         if (c_data[k+1] !== 10'sd0) begin
            n_fail++;
            $display("FAIL midrst_history_tap%0d: data=%0d required 0", k, c_data[k+1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_ordering();
      test_wrap();
      test_extremes();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
